// File: rtl/ifft_8_stream_if.sv
// Sample stream bundle for ifft_8_stream: frequency-domain input side and
// time-domain output side, each a valid/ready channel.
interface ifft_8_stream_if #(
  parameter int W = 8
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_real;
  logic signed [W-1:0] in_image;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_real;
  logic signed [W-1:0] out_image;
  logic                out_last;

  // Producer of frequency samples / consumer of time samples.
  modport master (
    output in_valid, in_real, in_image, out_ready,
    input  in_ready, out_valid, out_real, out_image, out_last
  );

  // The transform block itself.
  modport slave (
    input  in_valid, in_real, in_image, out_ready,
    output in_ready, out_valid, out_real, out_image, out_last
  );
endinterface

// File: rtl/ifft_8_stream.sv
// Streaming 8-point radix-2 inverse FFT. Samples are loaded in bit-reversed
// order, three in-place DIT stages run one per clock (each halving, for 1/8
// overall scaling), then samples are unloaded in natural order.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. A source holds valid and data stable until the transfer; ready
// never depends combinationally on valid in this block.
module ifft_8_stream #(
  parameter int W  = 8,
  parameter int N  = 3,
  parameter int CW = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  ifft_8_stream_if.slave bus,
  output logic           busy,
  output logic [1:0]     dbg_state
);

  localparam int PTS = 1 << N;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  localparam logic signed [W+1:0] SAT_HI = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SAT_LO = {3'b111, {(W-1){1'b0}}};

  state_t              state, state_nxt;
  logic [2:0]          wr_cnt, wr_cnt_nxt;
  logic [2:0]          rd_cnt, rd_cnt_nxt;
  logic [1:0]          stage, stage_nxt;
  logic signed [W-1:0] buf_re [PTS];
  logic signed [W-1:0] buf_im [PTS];
  logic [4*W-1:0]      bf_res [4];
  logic                in_fire;
  logic                out_fire;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  // Upper-half ("a") index of butterfly b in stage s.
  function automatic logic [2:0] pair_a(input logic [1:0] s, input logic [1:0] b);
    case (s)
      2'd0:    return {b, 1'b0};
      2'd1:    return {b[1], 1'b0, b[0]};
      default: return {1'b0, b};
    endcase
  endfunction

  // Lower-half ("b") index, always a + 2^s.
  function automatic logic [2:0] pair_b(input logic [1:0] s, input logic [1:0] b);
    case (s)
      2'd0:    return {b, 1'b1};
      2'd1:    return {b[1], 1'b1, b[0]};
      default: return {1'b1, b};
    endcase
  endfunction

  // Twiddle exp(+j*2*pi*m/2^(s+1)) expressed as an index into the eighth-turn table.
  function automatic logic [1:0] tw_idx(input logic [1:0] s, input logic [1:0] b);
    case (s)
      2'd0:    return 2'd0;
      2'd1:    return {b[0], 1'b0};
      default: return b;
    endcase
  endfunction

  function automatic logic signed [CW-1:0] tw_re(input logic [1:0] i);
    case (i)
      2'd0:    return CW'(128);
      2'd1:    return CW'(91);
      2'd2:    return CW'(0);
      default: return CW'(-91);
    endcase
  endfunction

  function automatic logic signed [CW-1:0] tw_im(input logic [1:0] i);
    case (i)
      2'd0:    return CW'(0);
      2'd1:    return CW'(91);
      2'd2:    return CW'(128);
      default: return CW'(91);
    endcase
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] v);
    if (v > SAT_HI)      return SAT_HI[W-1:0];
    else if (v < SAT_LO) return SAT_LO[W-1:0];
    else                 return v[W-1:0];
  endfunction

  // One scaled butterfly; returns {a_re, a_im, b_re, b_im}.
  function automatic logic [4*W-1:0] bfly(
    input logic signed [W-1:0]  a_re, a_im, b_re, b_im,
    input logic signed [CW-1:0] t_re, t_im
  );
    logic signed [W+CW:0] br, bi, tr, ti, pr_full, pi_full, pr_sh, pi_sh;
    logic signed [W+1:0]  p_re, p_im, a_xr, a_xi, s_re, s_im, d_re, d_im;
    br      = (W+CW+1)'(b_re);
    bi      = (W+CW+1)'(b_im);
    tr      = (W+CW+1)'(t_re);
    ti      = (W+CW+1)'(t_im);
    // Sum at full width, then a single floor shift back to sample scale.
    pr_full = br * tr - bi * ti;
    pi_full = br * ti + bi * tr;
    pr_sh   = pr_full >>> (CW - 2);
    pi_sh   = pi_full >>> (CW - 2);
    p_re    = pr_sh[W+1:0];
    p_im    = pi_sh[W+1:0];
    a_xr    = (W+2)'(a_re);
    a_xi    = (W+2)'(a_im);
    s_re    = a_xr + p_re;
    s_im    = a_xi + p_im;
    d_re    = a_xr - p_re;
    d_im    = a_xi - p_im;
    return {sat(s_re >>> 1), sat(s_im >>> 1), sat(d_re >>> 1), sat(d_im >>> 1)};
  endfunction

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  // All four butterflies of the current stage, evaluated in parallel.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      bf_res[b] = bfly(buf_re[pair_a(stage, 2'(b))], buf_im[pair_a(stage, 2'(b))],
                       buf_re[pair_b(stage, 2'(b))], buf_im[pair_b(stage, 2'(b))],
                       tw_re(tw_idx(stage, 2'(b))), tw_im(tw_idx(stage, 2'(b))));
    end
  end

  // Sample buffer: bit-reversed writes while loading, in-place stage updates while computing.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_re[bitrev3(wr_cnt)] <= bus.in_real;
      buf_im[bitrev3(wr_cnt)] <= bus.in_image;
    end else if (state == COMPUTE) begin
      for (int b = 0; b < 4; b++) begin
        buf_re[pair_a(stage, 2'(b))] <= bf_res[b][4*W-1:3*W];
        buf_im[pair_a(stage, 2'(b))] <= bf_res[b][3*W-1:2*W];
        buf_re[pair_b(stage, 2'(b))] <= bf_res[b][2*W-1:W];
        buf_im[pair_b(stage, 2'(b))] <= bf_res[b][W-1:0];
      end
    end
  end

  // Control registers: state and the three counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOAD;
      wr_cnt <= 3'd0;
      rd_cnt <= 3'd0;
      stage  <= 2'd0;
    end else begin
      state  <= state_nxt;
      wr_cnt <= wr_cnt_nxt;
      rd_cnt <= rd_cnt_nxt;
      stage  <= stage_nxt;
    end
  end

  // Next-state logic: load 8, compute 3 stages, unload 8.
  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    rd_cnt_nxt = rd_cnt;
    stage_nxt  = stage;
    case (state)
      LOAD: begin
        if (in_fire) begin
          wr_cnt_nxt = wr_cnt + 3'd1;
          if (wr_cnt == 3'd7) begin
            state_nxt = COMPUTE;
            stage_nxt = 2'd0;
          end
        end
      end
      COMPUTE: begin
        stage_nxt = stage + 2'd1;
        if (stage == 2'd2) begin
          state_nxt = UNLOAD;
          stage_nxt = 2'd0;
        end
      end
      UNLOAD: begin
        if (out_fire) begin
          rd_cnt_nxt = rd_cnt + 3'd1;
          if (rd_cnt == 3'd7) begin
            state_nxt  = LOAD;
            wr_cnt_nxt = 3'd0;
            rd_cnt_nxt = 3'd0;
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Outputs follow state directly; data is forced to zero when not valid.
  always_comb begin
    bus.in_ready  = (state == LOAD);
    bus.out_valid = (state == UNLOAD);
    bus.out_last  = (state == UNLOAD) && (rd_cnt == 3'd7);
    bus.out_real  = (state == UNLOAD) ? buf_re[rd_cnt] : '0;
    bus.out_image = (state == UNLOAD) ? buf_im[rd_cnt] : '0;
    busy          = (state != LOAD);
    dbg_state     = state;
  end

endmodule

// File: tb/tb_ifft_8_stream.sv
// Directed bench for ifft_8_stream: impulse, DC, single bin, gaps and
// backpressure, mid-frame resets and back-to-back frames.
module tb_ifft_8_stream;
  localparam int W = 8;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [1:0] dbg_state;

  ifft_8_stream_if #(.W(W)) bus ();

  ifft_8_stream #(.W(W), .N(3), .CW(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0]      exp_q[$];
  logic signed [W-1:0] fr_re [8];
  logic signed [W-1:0] fr_im [8];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // 0 = impulse X[0]=64, 1 = DC all 8, 2 = single bin X[1]=64
  task automatic set_frame(input int kind);
    for (int k = 0; k < 8; k++) begin
      fr_im[k] = '0;
      case (kind)
        0:       fr_re[k] = (k == 0) ? W'(64) : W'(0);
        1:       fr_re[k] = W'(8);
        default: fr_re[k] = (k == 1) ? W'(64) : W'(0);
      endcase
    end
  endtask

  task automatic push_exp(input int kind);
    int sb_re[8] = '{8, 5, 0, -6, -8, -6, 0, 6};
    int sb_im[8] = '{0, 5, 8, 5, 0, -6, -8, -6};
    for (int n = 0; n < 8; n++) begin
      case (kind)
        0:       exp_q.push_back({W'(8), W'(0)});
        1:       exp_q.push_back({(n == 0) ? W'(8) : W'(0), W'(0)});
        default: exp_q.push_back({W'(sb_re[n]), W'(sb_im[n])});
      endcase
    end
  endtask

  // Offer n_in samples from fr_*; optional 1/0 valid gaps. Called and returns at a negedge.
  task automatic load(input int n_in, input bit gaps, input bit hold_valid);
    int k = 0;
    int cyc = 0;
    while (k < n_in && cyc < 200) begin
      bus.in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      bus.in_real  = fr_re[k];
      bus.in_image = fr_im[k];
      if (bus.in_valid && bus.in_ready) k++;
      @(negedge clk);
      cyc++;
    end
    check("load_count", k, n_in);
    if (!hold_valid) bus.in_valid = 1'b0;
  endtask

  // Wait for compute, then take n_out outputs, stalling stall_len cycles at stall_idx.
  task automatic unload(input int n_out, input int stall_idx, input int stall_len);
    int lat = 0;
    int n = 0;
    int stalled = 0;
    int cyc = 0;
    logic [2*W-1:0] e;
    while (!bus.out_valid && lat < 50) begin
      check("compute_in_ready", bus.in_ready, 0);
      check("compute_busy", busy, 1);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, 3);
    while (n < n_out && cyc < 100) begin
      if (n == stall_idx && stalled < stall_len) begin
        bus.out_ready = 1'b0;
        stalled++;
      end else begin
        bus.out_ready = 1'b1;
      end
      e = exp_q[0];
      check("out_valid", bus.out_valid, 1);
      check("unload_in_ready", bus.in_ready, 0);
      check("unload_state", dbg_state, 2);
      check("x_real", bus.out_real, $signed(e[2*W-1:W]));
      check("x_image", bus.out_image, $signed(e[W-1:0]));
      check("out_last", bus.out_last, (n == 7) ? 1 : 0);
      if (bus.out_ready) begin
        void'(exp_q.pop_front());
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b1;
    if (n_out == 8) begin
      check("post_out_valid", bus.out_valid, 0);
      check("post_in_ready", bus.in_ready, 1);
      check("post_busy", busy, 0);
      check("post_out_real", bus.out_real, 0);
      check("post_out_last", bus.out_last, 0);
    end
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_real", bus.out_real, 0);
    check("rst_out_image", bus.out_image, 0);
    check("rst_state", dbg_state, 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_real   = '0;
    bus.in_image  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);

    // impulse
    set_frame(0); push_exp(0);
    load(8, 1'b0, 1'b0); unload(8, -1, 0);

    // DC
    set_frame(1); push_exp(1);
    load(8, 1'b0, 1'b0); unload(8, -1, 0);

    // single bin
    set_frame(2); push_exp(2);
    load(8, 1'b0, 1'b0); unload(8, -1, 0);

    // input gaps, 3-cycle stall at x[2]
    set_frame(2); push_exp(2);
    load(8, 1'b1, 1'b0); unload(8, 2, 3);

    // reset after 5 inputs
    set_frame(2);
    load(5, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_frame(0); push_exp(0);
    load(8, 1'b0, 1'b0); unload(8, -1, 0);

    // reset during unload after 3 outputs
    set_frame(2); push_exp(2);
    load(8, 1'b0, 1'b0); unload(3, -1, 0);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_frame(0); push_exp(0);
    load(8, 1'b0, 1'b0); unload(8, -1, 0);

    // back-to-back: second X[0] offered throughout compute/unload of frame 1
    set_frame(0); push_exp(0);
    load(8, 1'b0, 1'b1);
    bus.in_real  = fr_re[0];
    bus.in_image = fr_im[0];
    unload(8, -1, 0);
    check("b2b_ready", bus.in_ready, 1);
    push_exp(0);
    load(8, 1'b0, 1'b0); unload(8, -1, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
